// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and sizing helpers for serial_adder.
// calc_n gives digits per operation; cnt_w gives digit counter width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width is $clog2(N) but never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple chain of full-adder cells.
// Ports: x, y, ci in; s, co, c_msb_in (carry into the top bit) out.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  always_comb begin
    logic c;
    c        = ci;
    s        = '0;
    c_msb_in = ci;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in = c;
      s[i]     = x[i] ^ y[i] ^ c;
      c        = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial WIDTH-bit adder, DIGIT bits/clock, LSB first.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, sub,
//   out_valid/out_ready, sum, cout, ovf.
// Macro SERIAL_ADDER_SUB_EN enables subtract mode (a - b - cin).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dx, dy, ds;
  logic             dco, dmsb;

  assign dx = a_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign dy = b_q[int'(cnt_q)*DIGIT +: DIGIT];

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (dx),
    .y        (dy),
    .ci       (carry_q),
    .s        (ds),
    .co       (dco),
    .c_msb_in (dmsb)
  );

`ifndef SERIAL_ADDER_SUB_EN
  logic sub_unused;
  assign sub_unused = sub;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtract as a + ~b + ~cin; B is inverted once at latch.
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
`else
          b_d     = b;
          carry_d = cin;
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q)*DIGIT +: DIGIT] = ds;
        carry_d = dco;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = dco;
          ovf_d   = dco ^ dmsb;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed test of serial_adder, DIGIT=1 and DIGIT=4.
// Reference model checks handshakes and results every cycle.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] a, b;
  logic       cin, sub;
  logic       iv [2];
  logic       ir [2];
  logic       ov [2];
  logic       ordy [2];
  logic       co_o [2];
  logic       ovf_o [2];
  logic [7:0] sum_o [2];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sum_o[0]), .cout(co_o[0]), .ovf(ovf_o[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sum_o[1]), .cout(co_o[1]), .ovf(ovf_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int nd [2] = '{8, 2};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: returns {ovf, cout, sum}.
  function automatic logic [9:0] ref_calc(input logic [7:0] aa,
      input logic [7:0] bb, input logic c, input logic s);
    int ua, ub, sa, sb, ru, rs;
    logic co, ovv;
    ua = int'(aa);
    ub = int'(bb);
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    ru = ua + ub + int'(c);
    rs = sa + sb + int'(c);
    co = (ru > 255);
`ifdef SERIAL_ADDER_SUB_EN
    if (s) begin
      ru = ua - ub - int'(c);
      rs = sa - sb - int'(c);
      co = (ru >= 0);
    end
`else
    if (s === 1'bx) co = 1'bx;
`endif
    ovv = (rs > 127) || (rs < -128);
    return {ovv, co, ru[7:0]};
  endfunction

  // Model: 0 idle, 1 running (left digits), 2 result held.
  int         ph [2] = '{0, 0};
  int         left [2];
  logic [7:0] e_sum [2];
  logic       e_co [2];
  logic       e_ovf [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ph[d] <= 0;
      end else if (ph[d] == 0) begin
        if (iv[d]) begin
          {e_ovf[d], e_co[d], e_sum[d]} <= ref_calc(a, b, cin, sub);
          left[d] <= nd[d];
          ph[d]   <= 1;
        end
      end else if (ph[d] == 1) begin
        left[d] <= left[d] - 1;
        if (left[d] == 1) ph[d] <= 2;
      end else begin
        if (ordy[d]) ph[d] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_in_ready", d), 32'(ir[d]), 32'(ph[d] == 0));
      chk($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(ph[d] == 2));
      if (ph[d] == 2) begin
        chk($sformatf("d%0d_sum", d), 32'(sum_o[d]), 32'(e_sum[d]));
        chk($sformatf("d%0d_cout", d), 32'(co_o[d]), 32'(e_co[d]));
        chk($sformatf("d%0d_ovf", d), 32'(ovf_o[d]), 32'(e_ovf[d]));
      end
    end
  end

  task automatic op(input int d, input logic [7:0] aa, input logic [7:0] bb,
                    input logic c, input logic s, input logic [7:0] es,
                    input logic ec, input logic eo, input int hold);
    int t;
    int n;
    logic [7:0] h_sum;
    logic h_co, h_ovf;
    @(negedge clk);
    a = aa; b = bb; cin = c; sub = s;
    iv[d] = 1'b1;
    ordy[d] = 1'b0;
    t = 0;
    while (!ir[d] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      chk("accept_timeout", 32'(0), 32'(1));
      iv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 iv[d] = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1 n++;
      if (ov[d]) break;
    end
    if (!ov[d]) begin
      chk("out_valid_timeout", 32'(0), 32'(1));
      return;
    end
    chk($sformatf("d%0d_latency", d), 32'(n), 32'(nd[d]));
    chk("lit_sum", 32'(sum_o[d]), 32'(es));
    chk("lit_cout", 32'(co_o[d]), 32'(ec));
    chk("lit_ovf", 32'(ovf_o[d]), 32'(eo));
    h_sum = sum_o[d]; h_co = co_o[d]; h_ovf = ovf_o[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_sum", 32'(sum_o[d]), 32'(h_sum));
      chk("hold_cout", 32'(co_o[d]), 32'(h_co));
      chk("hold_ovf", 32'(ovf_o[d]), 32'(h_ovf));
      chk("hold_in_ready", 32'(ir[d]), 32'(0));
      chk("hold_out_valid", 32'(ov[d]), 32'(1));
    end
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    chk("ret_in_ready", 32'(ir[d]), 32'(1));
    chk("ret_out_valid", 32'(ov[d]), 32'(0));
    ordy[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    iv[0] = 1'b0; iv[1] = 1'b0;
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(ir[0]), 32'(1));
    chk("rst_out_valid", 32'(ov[0]), 32'(0));
    chk("rst_sum", 32'(sum_o[0]), 32'(0));
    chk("rst_cout", 32'(co_o[0]), 32'(0));
    chk("rst_ovf", 32'(ovf_o[0]), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 0);
    op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    op(1, 8'h9A, 8'h77, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 0);
    op(1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    op(0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b0, 5);
    op(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 0);
`ifdef SERIAL_ADDER_SUB_EN
    op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    op(1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
`else
    op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 0);
    op(1, 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 0);
`endif

    // Reset in the middle of a RUN on the DIGIT=1 instance.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 32'(0));
    chk("midrst_sum", 32'(sum_o[0]), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_valid", 32'(ov[0]), 32'(0));
    end
    chk("post_rst_in_ready", 32'(ir[0]), 32'(1));
    ordy[0] = 1'b0;
    op(0, 8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Parametrised, multi-cycle successor to the single-bit full-adder cell.
- Adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first. A registered carry links the digits.
- Input and output use valid/ready handshakes.
- Used as the area-cheap arithmetic unit in datapaths where latency of WIDTH/DIGIT cycles is acceptable.

## Interface
Parameters:
- WIDTH, 8, operand and sum width; must be ≥ 1.
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must be 0; otherwise elaboration fails. DIGIT == WIDTH is legal.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when subtracting).
- sub  input  1  subtract mode select; see Configuration.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (not-borrow when subtracting).
- ovf  output  1  signed two's-complement overflow.

## Operation
- N = WIDTH/DIGIT. The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: latch a, b, effective carry-in and mode; clear digit counter; go to RUN.
- **RUN**
  - Each cycle, add the current DIGIT-bit slice of A and B plus the carry register.
  - Store the slice result into sum bits [k*DIGIT +: DIGIT]; update the carry register; increment the counter.
  - On the cycle processing digit N-1:
    - cout = final carry.
    - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Next state is DONE.
- **DONE**
  - out_valid = 1; sum, cout and ovf are held stable.
  - On out_ready: go to IDLE.
- in_ready = 0 in RUN and DONE. Inputs are ignored there; there is no overlap between operations.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^WIDTH with carry out.
- sum, cout and ovf are defined only while out_valid = 1. sum may change during RUN.
- Reset (any state, any cycle):
  - State → IDLE; counter and carry register → 0.
  - sum, cout, ovf, out_valid → 0; in_ready → 1 after reset deasserts.
  - An operation in flight when reset asserts is discarded and produces no output.

## Timing
- Accept edge T0 is the edge where in_valid && in_ready = 1.
- RUN occupies the N cycles after T0. out_valid rises after edge T0+N.
- Latency from accept to out_valid is exactly N cycles, independent of out_ready.
- If out_ready = 1 in the first DONE cycle, the block returns to IDLE at edge T0+N+1. in_ready is high in the following cycle.
- Maximum throughput is one operation per N+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready = 0, with outputs unchanged.
- Output signals are all registered except in_ready and out_valid. Those two decode the state register directly, with no combinational path from inputs.
- N = 1: RUN lasts one cycle.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- **Defined:**
  - sub latched with the operands.
  - When sub = 1: result = a − b − cin, computed as a + ~b + ~cin.
  - cout = 1 means no borrow.
  - ovf uses the same signed rule.
- **Undefined:** sub is ignored; the block only adds; no inversion logic is synthesised.

## Structure
- Package serial_adder_pkg holds:
  - The state typedef (IDLE, RUN, DONE).
  - A function computing N and the counter width, $clog2(N) with a minimum of 1.
- Sub-module digit_adder: combinational DIGIT-bit ripple chain of full-adder cells.
  - Inputs: x, y, ci. Outputs: s, co, and c_msb_in (carry into the top bit, used for ovf).
  - Instantiated once.

## Test plan
- Basic add (WIDTH=8, DIGIT=1): a=0x3C, b=0x05, cin=0 → after 8 cycles sum=0x41, cout=0, ovf=0.
- Carry/overflow: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
- Digit mode (WIDTH=8, DIGIT=4): a=0x9A, b=0x77, cin=1 → out_valid exactly 2 cycles after accept; sum=0x12, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum, cout and ovf stable; in_ready=0 throughout; one cycle after out_ready=1, in_ready=1. A second operation offered in that IDLE cycle is accepted.
- Reset mid-op: assert rst_n=0 at RUN cycle 3 → out_valid=0, sum=0 immediately. After release: in_ready=1, and no stale result ever appears.
- SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07, cin=0 → sum=0xFE, cout=0. With the macro undefined, the same stimulus gives sum=0x0C.
